// File: rtl/bin2bcd_hs.sv
// bin2bcd_hs: sequential binary-to-BCD converter (shift-add-3) with
// valid/ready handshakes, overflow saturation and significant-digit count.
//
// Ports:
//   clk, rst_n        clock, async active-low reset
//   din/din_vld/din_rdy        binary input handshake (din_rdy only in IDLE)
//   bcd_dout/dout_vld/dout_rdy BCD result handshake, digit k in [4k+3:4k]
//   sign              result negative (signed build only, else 0)
//   ndigits           significant digits (1 for zero, DIGITS on overflow)
//   ovf               value exceeded 10^DIGITS-1 (bcd_dout saturates to 9s)
//
// Build option: define BIN2BCD_SIGNED_EN to treat din as two's complement.
module bin2bcd_hs #(
   parameter int DIN_W  = 20,
   parameter int DIGITS = 7,
   localparam int NDW   = $clog2(DIGITS + 1)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [DIN_W-1:0]      din,
   input  logic                  din_vld,
   output logic                  din_rdy,
   output logic [4*DIGITS-1:0]   bcd_dout,
   output logic                  sign,
   output logic [NDW-1:0]        ndigits,
   output logic                  ovf,
   output logic                  dout_vld,
   input  logic                  dout_rdy
);

   localparam int CW = $clog2(DIN_W);
   localparam int BW = 4 * DIGITS;

   typedef enum logic [2:0] {
      S_IDLE  = 3'b001,
      S_SHIFT = 3'b010,
      S_DONE  = 3'b100
   } state_t;

   state_t state, state_nxt;

   logic [CW-1:0]    cnt;
   logic [DIN_W-1:0] sr, sr_nxt, mag;
   logic [BW-1:0]    dig, adj, dig_nxt;
   logic             ovf_q, ovf_nxt, sh_out;
   logic [NDW-1:0]   nd_nxt;
   logic             accept, last, take;

   assign din_rdy = (state == S_IDLE);
   assign accept  = din_vld && din_rdy;
   assign last    = (cnt == CW'(DIN_W - 1));
   assign take    = dout_vld && dout_rdy;

   // add-3 correction, then shift {digits, sr} left; the bit leaving the
   // top digit means the value no longer fits in DIGITS digits
   always_comb begin
      adj = '0;
      for (int k = 0; k < DIGITS; k++) begin
         if (dig[4*k +: 4] >= 4'd5)
            adj[4*k +: 4] = dig[4*k +: 4] + 4'd3;
         else
            adj[4*k +: 4] = dig[4*k +: 4];
      end
   end

   assign {sh_out, dig_nxt, sr_nxt} = {adj, sr, 1'b0};
   assign ovf_nxt = ovf_q | sh_out;

   always_comb begin
      nd_nxt = NDW'(1);
      for (int k = 0; k < DIGITS; k++) begin
         if (dig_nxt[4*k +: 4] != 4'd0)
            nd_nxt = NDW'(k + 1);
      end
      if (ovf_nxt)
         nd_nxt = NDW'(DIGITS);
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (din_vld)  state_nxt = S_SHIFT;
         S_SHIFT: if (last)     state_nxt = S_DONE;
         S_DONE:  if (take)     state_nxt = S_IDLE;
         default:               state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= S_IDLE;
      else
         state <= state_nxt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sr    <= '0;
         dig   <= '0;
         ovf_q <= 1'b0;
         cnt   <= '0;
      end else if (accept) begin
         sr    <= mag;
         dig   <= '0;
         ovf_q <= 1'b0;
         cnt   <= '0;
      end else if (state == S_SHIFT) begin
         sr    <= sr_nxt;
         dig   <= dig_nxt;
         ovf_q <= ovf_nxt;
         if (!last)
            cnt <= cnt + 1'b1;
      end
   end

   // result registers load on the DONE entry edge; dout_vld follows one
   // cycle later so the outputs are settled a full cycle before offered
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bcd_dout <= '0;
         ovf      <= 1'b0;
         ndigits  <= NDW'(1);
         dout_vld <= 1'b0;
      end else begin
         if (state == S_SHIFT && last) begin
            bcd_dout <= ovf_nxt ? {DIGITS{4'h9}} : dig_nxt;
            ovf      <= ovf_nxt;
            ndigits  <= nd_nxt;
         end
         dout_vld <= (state == S_DONE) && (state_nxt == S_DONE);
      end
   end

`ifdef BIN2BCD_SIGNED_EN
   logic sign_q;

   // ~din+1 of the most negative value is its correct unsigned magnitude
   assign mag = din[DIN_W-1] ? (~din + 1'b1) : din;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sign_q <= 1'b0;
         sign   <= 1'b0;
      end else begin
         if (accept)
            sign_q <= din[DIN_W-1];
         if (state == S_SHIFT && last)
            sign <= sign_q;
      end
   end
`else
   assign mag  = din;
   assign sign = 1'b0;
`endif

endmodule
